// File: rtl/regbank_dump_ctrl_pkg.sv
// Shared definitions for the register-bank dump sequencer.
//   dump_state_e : sequencer states (idle, settle, header, latch, send, finish)
//   DumpDataW    : default register width
//   DumpHeader   : default first byte of every dump
package regbank_dump_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSettle = 3'd1,
        StHdr    = 3'd2,
        StLatch  = 3'd3,
        StSend   = 3'd4,
        StFin    = 3'd5
    } dump_state_e;

    localparam int unsigned DumpDataW  = 32;
    localparam logic [7:0]  DumpHeader = 8'hA5;

endpackage

// File: rtl/regbank_dump_ctrl.sv
// Debug sequencer that freezes the pipeline and streams the whole register bank out as bytes.
// Sequence: header byte, then each register MSB byte first, over a valid/ready byte link.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   start         : one-cycle dump request (ignored while a dump is running)
//   stall_req     : held high for the whole dump, ORed into the pipeline stall
//   addr_async    : register bank asynchronous read address
//   data_async    : register bank asynchronous read data for addr_async
//   tx_valid/tx_data/tx_ready : byte stream toward the UART transmitter
//   busy          : dump in progress
//   done          : one-cycle pulse after the final byte is accepted
module regbank_dump_ctrl
    import regbank_dump_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS      = 32,
    parameter int unsigned ADDR_W        = 5,
    parameter int unsigned DATA_W        = DumpDataW,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  HEADER        = DumpHeader
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              stall_req,
    output logic [ADDR_W-1:0] addr_async,
    input  logic [DATA_W-1:0] data_async,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned NumBytes = DATA_W / 8;
    localparam int unsigned ByteW    = (NumBytes > 1) ? $clog2(NumBytes) : 1;

    localparam logic [3:0]        SettleInit = 4'(SETTLE_CYCLES);
    localparam logic [ByteW-1:0]  LastByte   = ByteW'(NumBytes - 1);
    localparam logic [ADDR_W-1:0] LastAddr   = ADDR_W'(NUM_REGS - 1);

    dump_state_e       state_q, state_d;
    logic [3:0]        settle_q, settle_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] shift_q, shift_d, shift_next;
    logic [ByteW-1:0]  idx_q, idx_d;
    logic              stall_q, stall_d;
    logic              valid_q, valid_d;
    logic [7:0]        data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    assign shift_next = shift_q << 8;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        addr_d   = addr_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        stall_d  = stall_q;
        valid_d  = valid_q;
        data_d   = data_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StSettle;
                    stall_d  = 1'b1;
                    busy_d   = 1'b1;
                    settle_d = SettleInit;
                    addr_d   = '0;
                end
            end
            // Lets writebacks already in flight retire before any register is sampled.
            StSettle: begin
                if (settle_q == 4'd0) begin
                    state_d = StHdr;
                    valid_d = 1'b1;
                    data_d  = HEADER;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            StHdr: begin
                if (tx_ready) begin
                    state_d = StLatch;
                    valid_d = 1'b0;
                end
            end
            // Outputs are registered, so the first byte comes straight from the read port.
            StLatch: begin
                shift_d = data_async;
                idx_d   = '0;
                valid_d = 1'b1;
                data_d  = data_async[DATA_W-1 -: 8];
                state_d = StSend;
            end
            StSend: begin
                if (tx_ready) begin
                    shift_d = shift_next;
                    idx_d   = idx_q + 1'b1;
                    data_d  = shift_next[DATA_W-1 -: 8];
                    if (idx_q == LastByte) begin
                        valid_d = 1'b0;
                        if (addr_q == LastAddr) begin
                            state_d = StFin;
                            done_d  = 1'b1;
                            stall_d = 1'b0;
                            busy_d  = 1'b0;
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            state_d = StLatch;
                        end
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
                addr_d  = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            settle_q <= '0;
            addr_q   <= '0;
            shift_q  <= '0;
            idx_q    <= '0;
            stall_q  <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            addr_q   <= addr_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            stall_q  <= stall_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign stall_req  = stall_q;
    assign addr_async = addr_q;
    assign tx_valid   = valid_q;
    assign tx_data    = data_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_regbank_dump_ctrl.sv
// Scoreboard bench for regbank_dump_ctrl: expected byte streams are built from a register-bank
// array and queued at stimulus time; a negedge monitor pops and compares accepted bytes.
module tb_regbank_dump_ctrl;

    localparam int NumRegs = 32;
    localparam int DumpLen = 1 + NumRegs * 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        stall_req;
    logic [4:0]  addr_async;
    logic [31:0] data_async;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        busy;
    logic        done;

    logic [31:0] regs [NumRegs];
    assign data_async = regs[addr_async];

    regbank_dump_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .stall_req  (stall_req),
        .addr_async (addr_async),
        .data_async (data_async),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    int        tests_run = 0;
    int        fails     = 0;
    int        done_cnt  = 0;
    int        dump_bytes = 0;
    bit        ready_rand = 1'b0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests_run++;
        fails++;
        $display("FAIL %s", name);
    endtask

    // Reference stream: header then every register, most significant byte first.
    task automatic push_expected();
        logic [31:0] w;
        exp_q.push_back(8'hA5);
        for (int r = 0; r < NumRegs; r++) begin
            w = regs[r];
            for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
        end
    endtask

    // Consumer readiness changes just after each rising edge.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            tx_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: accepted bytes, handshake stability and done pulses.
    bit         pend_valid = 1'b0;
    logic [7:0] pend_data;
    always @(negedge clock) begin
        logic [7:0] e;
        if (reset) begin
            pend_valid = 1'b0;
        end else begin
            if (pend_valid) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_data", 32'(tx_data), 32'(pend_data));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_byte");
                end else begin
                    e = exp_q.pop_front();
                    check("byte", 32'(tx_data), 32'(e));
                end
                dump_bytes++;
            end
            pend_valid = tx_valid && !tx_ready;
            pend_data  = tx_data;
            if (done) begin
                done_cnt++;
                check("done_queue_empty", 32'(exp_q.size()), 32'd0);
                check("done_stall_low", 32'(stall_req), 32'd0);
                check("done_busy_low", 32'(busy), 32'd0);
                check("done_valid_low", 32'(tx_valid), 32'd0);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        int c = 0;
        while (dump_bytes < n && c < 2000) begin
            @(posedge clock);
            #1;
            c++;
        end
        if (dump_bytes < n) fail_now("timeout_bytes");
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int c  = 0;
        while (done_cnt == d0 && c < 3000) begin
            @(posedge clock);
            #1;
            c++;
        end
        if (done_cnt == d0) fail_now("timeout_done");
    endtask

    task automatic finish_checks(input string tag, input int d0);
        check({tag, "_bytes"}, 32'(dump_bytes), 32'(DumpLen));
        check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_stall_after"}, 32'(stall_req), 32'd0);
    endtask

    initial begin
        int d0;
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < NumRegs; i++) regs[i] = 32'h01010101 * i;
        repeat (3) @(posedge clock);
        #1;
        start = 1'b1;  // start during reset is ignored
        @(posedge clock);
        #1;
        start = 1'b0;
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_addr", 32'(addr_async), 32'd0);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("idle_after_rst", 32'(busy), 32'd0);

        // Ramp pattern, ready held high, plus start-to-header latency.
        push_expected();
        dump_bytes = 0;
        d0 = done_cnt;
        pulse_start();
        check("lat_stall_c1", 32'(stall_req), 32'd1);
        check("lat_busy_c1", 32'(busy), 32'd1);
        check("lat_valid_c1", 32'(tx_valid), 32'd0);
        @(posedge clock);
        #1;
        check("lat_valid_c2", 32'(tx_valid), 32'd0);
        @(posedge clock);
        #1;
        check("lat_valid_c3", 32'(tx_valid), 32'd0);
        @(posedge clock);
        #1;
        check("lat_valid_c4", 32'(tx_valid), 32'd1);
        check("lat_hdr_c4", 32'(tx_data), 32'hA5);
        wait_done();
        finish_checks("ramp", d0);

        // Random readiness with a distinctive register value.
        ready_rand = 1'b1;
        regs[5] = 32'hDEADBEEF;
        push_expected();
        dump_bytes = 0;
        d0 = done_cnt;
        pulse_start();
        wait_done();
        finish_checks("rand_ready", d0);

        // Second start mid-dump must be ignored.
        for (int i = 0; i < NumRegs; i++) regs[i] = $urandom;
        push_expected();
        dump_bytes = 0;
        d0 = done_cnt;
        pulse_start();
        wait_bytes(40);
        pulse_start();
        wait_done();
        finish_checks("restart_ignored", d0);
        repeat (30) @(posedge clock);
        #1;
        check("restart_no_second_dump", 32'(done_cnt - d0), 32'd1);
        check("restart_idle", 32'(busy), 32'd0);

        // Reset mid-dump abandons the stream, then a fresh full dump.
        for (int i = 0; i < NumRegs; i++) regs[i] = $urandom;
        push_expected();
        dump_bytes = 0;
        d0 = done_cnt;
        pulse_start();
        wait_bytes(60);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midrst_stall", 32'(stall_req), 32'd0);
        check("midrst_valid", 32'(tx_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        repeat (20) @(posedge clock);
        #1;
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        check("midrst_idle_valid", 32'(tx_valid), 32'd0);
        push_expected();
        dump_bytes = 0;
        pulse_start();
        wait_done();
        finish_checks("after_rst", d0);

        // A writeback retiring during the settle window is captured.
        ready_rand = 1'b0;
        for (int i = 0; i < NumRegs; i++) regs[i] = 32'h01010101 * i;
        dump_bytes = 0;
        d0 = done_cnt;
        pulse_start();
        check("settle_stall", 32'(stall_req), 32'd1);
        regs[7] = 32'h12345678;
        push_expected();
        wait_done();
        finish_checks("settle_write", d0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
